// File: rtl/esn_step_sequencer.sv
// Time-step scheduler for the integer ESN core.
// Runs iNumSteps reservoir updates per sequence; after the first iWashout steps each
// reservoir step is followed by one interpreter (readout) pass.
module esn_step_sequencer #(
    parameter int unsigned STEP_W = 16
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic [STEP_W-1:0] iNumSteps,
    input  logic [STEP_W-1:0] iWashout,
    output logic              oResStart,
    input  logic              iResDone,
    output logic              oIntStart,
    input  logic              iIntDone,
    output logic [STEP_W-1:0] oStepIdx,
    output logic              oOutValid,
    output logic              oBusy,
    output logic              oDone
);

    localparam logic [STEP_W-1:0] One = STEP_W'(1);

    typedef enum logic [2:0] {
        StIdle    = 3'b001,
        StResWait = 3'b010,
        StIntWait = 3'b100
    } state_t;

    state_t            state;
    logic [STEP_W-1:0] numSteps;
    logic [STEP_W-1:0] washout;
    // Set on the edge a step finishes; the index bump and next oResStart follow one edge later
    logic              advPend;
    logic              lastStep;

    // Current step is the final one of the latched sequence
    assign lastStep = (oStepIdx == (numSteps - One));

    // Sequencer FSM with registered handshake pulses and status outputs
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= StIdle;
            numSteps  <= '0;
            washout   <= '0;
            advPend   <= 1'b0;
            oStepIdx  <= '0;
            oResStart <= 1'b0;
            oIntStart <= 1'b0;
            oOutValid <= 1'b0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
        end else begin
            oResStart <= 1'b0;
            oIntStart <= 1'b0;
            oOutValid <= 1'b0;
            oDone     <= 1'b0;
            case (state)
                StIdle: begin
                    if (iStart) begin
                        if (iNumSteps != '0) begin
                            numSteps  <= iNumSteps;
                            washout   <= iWashout;
                            oStepIdx  <= '0;
                            oBusy     <= 1'b1;
                            oResStart <= 1'b1;
                            advPend   <= 1'b0;
                            state     <= StResWait;
                        end else begin
                            oDone <= 1'b1;
                        end
                    end
                end
                StResWait: begin
                    if (iAbort) begin
                        oBusy   <= 1'b0;
                        advPend <= 1'b0;
                        state   <= StIdle;
                    end else if (advPend) begin
                        advPend   <= 1'b0;
                        oStepIdx  <= oStepIdx + One;
                        oResStart <= 1'b1;
                    end else if (iResDone && !oResStart) begin
                        if (oStepIdx >= washout) begin
                            oIntStart <= 1'b1;
                            state     <= StIntWait;
                        end else if (lastStep) begin
                            oDone <= 1'b1;
                            oBusy <= 1'b0;
                            state <= StIdle;
                        end else begin
                            advPend <= 1'b1;
                        end
                    end
                end
                StIntWait: begin
                    if (iAbort) begin
                        oBusy   <= 1'b0;
                        advPend <= 1'b0;
                        state   <= StIdle;
                    end else if (iIntDone && !oIntStart) begin
                        oOutValid <= 1'b1;
                        if (lastStep) begin
                            oDone <= 1'b1;
                            oBusy <= 1'b0;
                            state <= StIdle;
                        end else begin
                            advPend <= 1'b1;
                            state   <= StResWait;
                        end
                    end
                end
                default: begin
                    oBusy   <= 1'b0;
                    advPend <= 1'b0;
                    state   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_esn_step_sequencer.sv
// Directed bench for esn_step_sequencer with a simple datapath responder and pulse monitor.
module tb_esn_step_sequencer;

    logic        iClk, iRst_n, iStart, iAbort, iResDone, iIntDone;
    logic [15:0] iNumSteps, iWashout, oStepIdx;
    logic        oResStart, oIntStart, oOutValid, oBusy, oDone;

    int nTests = 0;
    int nFail  = 0;

    // Responder and monitor state
    bit          respEn = 0;
    int          dly = 3;
    int unsigned cyc = 0;
    logic [15:0] curW = '0;
    int          resCnt, intCnt, doneCnt, wideCnt, monoErr, earlyInt;
    logic [15:0] validIdx[$];
    int unsigned resCyc[$];
    bit          prevRes, prevInt, prevVal, prevDone, prevBusy;
    logic [15:0] prevIdx;

    esn_step_sequencer #(.STEP_W(16)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iAbort(iAbort),
        .iNumSteps(iNumSteps), .iWashout(iWashout), .oResStart(oResStart),
        .iResDone(iResDone), .oIntStart(oIntStart), .iIntDone(iIntDone),
        .oStepIdx(oStepIdx), .oOutValid(oOutValid), .oBusy(oBusy), .oDone(oDone)
    );

    initial iClk = 0;
    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    // Monitor: counts pulses, flags over-long pulses, index regressions and early readouts
    always @(negedge iClk) begin
        if (oResStart) begin resCnt++; resCyc.push_back(cyc); if (prevRes) wideCnt++; end
        if (oIntStart) begin intCnt++; if (prevInt) wideCnt++; if (oStepIdx < curW) earlyInt++; end
        if (oOutValid) begin validIdx.push_back(oStepIdx); if (prevVal) wideCnt++; end
        if (oDone) begin doneCnt++; if (prevDone) wideCnt++; end
        if (oBusy && prevBusy && oStepIdx < prevIdx) monoErr++;
        prevRes = oResStart; prevInt = oIntStart; prevVal = oOutValid;
        prevDone = oDone; prevBusy = oBusy; prevIdx = oStepIdx;
    end

    // Datapath model: answers each start pulse dly cycles after the launching edge
    initial begin
        iResDone = 0; iIntDone = 0;
        forever begin
            if (respEn && oResStart) begin
                repeat (dly - 1) @(negedge iClk);
                iResDone = 1; @(negedge iClk); iResDone = 0;
            end else if (respEn && oIntStart) begin
                repeat (dly - 1) @(negedge iClk);
                iIntDone = 1; @(negedge iClk); iIntDone = 0;
            end else begin
                @(negedge iClk);
            end
        end
    end

    task automatic clearMon();
        resCnt = 0; intCnt = 0; doneCnt = 0; wideCnt = 0; monoErr = 0; earlyInt = 0;
        validIdx.delete(); resCyc.delete();
    endtask

    task automatic startSeq(input logic [15:0] n, input logic [15:0] w);
        @(negedge iClk);
        iNumSteps = n; iWashout = w; curW = w; iStart = 1;
        @(negedge iClk);
        iStart = 0;
    endtask

    task automatic waitDone(input int maxCyc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxCyc && !ok; i++) begin
            @(negedge iClk);
            if (oDone === 1'b1) ok = 1;
        end
        repeat (2) @(negedge iClk);
    endtask

    task automatic test_reset();
        #3;
        nTests++;
        if ({oResStart, oIntStart, oOutValid, oBusy, oDone, oStepIdx} !== 21'd0) begin
            nFail++; $display("FAIL reset_vals: got %h required 0",
                              {oResStart, oIntStart, oOutValid, oBusy, oDone, oStepIdx});
        end
        @(negedge iClk); iRst_n = 1;
        repeat (2) @(negedge iClk);
        nTests++;
        if ({oResStart, oBusy, oDone} !== 3'b000) begin
            nFail++; $display("FAIL post_reset_idle: got %b required 000", {oResStart, oBusy, oDone});
        end
    endtask

    task automatic test_readout();
        bit ok;
        clearMon(); respEn = 1; dly = 3;
        startSeq(16'd4, 16'd2);
        nTests++;
        if (oResStart !== 1'b1 || oBusy !== 1'b1 || oStepIdx !== 16'd0) begin
            nFail++; $display("FAIL t1_first_pulse: got res=%b busy=%b idx=%0d required 1 1 0",
                              oResStart, oBusy, oStepIdx);
        end
        waitDone(200, ok);
        nTests++;
        if (!ok) begin nFail++; $display("FAIL t1_timeout: got no oDone required oDone"); end
        nTests++;
        if (resCnt != 4 || intCnt != 2 || doneCnt != 1) begin
            nFail++; $display("FAIL t1_counts: got res=%0d int=%0d done=%0d required 4 2 1",
                              resCnt, intCnt, doneCnt);
        end
        nTests++;
        if (validIdx.size() != 2 || validIdx[0] != 16'd2 || validIdx[1] != 16'd3) begin
            nFail++; $display("FAIL t1_valid_idx: got %0d valids required idx 2,3", validIdx.size());
        end
        nTests++;
        if (oStepIdx !== 16'd3 || oBusy !== 1'b0) begin
            nFail++; $display("FAIL t1_final: got idx=%0d busy=%b required 3 0", oStepIdx, oBusy);
        end
        nTests++;
        if (wideCnt != 0 || monoErr != 0 || earlyInt != 0) begin
            nFail++; $display("FAIL t1_pulse_rules: got wide=%0d mono=%0d early=%0d required 0 0 0",
                              wideCnt, monoErr, earlyInt);
        end
    endtask

    task automatic test_zero_steps();
        clearMon(); respEn = 1;
        startSeq(16'd0, 16'd0);
        nTests++;
        if (oDone !== 1'b1 || oBusy !== 1'b0 || oResStart !== 1'b0) begin
            nFail++; $display("FAIL t2_done: got done=%b busy=%b res=%b required 1 0 0",
                              oDone, oBusy, oResStart);
        end
        @(negedge iClk);
        nTests++;
        if (oDone !== 1'b0) begin nFail++; $display("FAIL t2_done_width: got %b required 0", oDone); end
        repeat (3) @(negedge iClk);
        nTests++;
        if (resCnt != 0 || doneCnt != 1) begin
            nFail++; $display("FAIL t2_counts: got res=%0d done=%0d required 0 1", resCnt, doneCnt);
        end
    endtask

    task automatic test_washout_covers_all();
        bit ok;
        clearMon(); respEn = 1; dly = 3;
        startSeq(16'd3, 16'd5);
        waitDone(200, ok);
        nTests++;
        if (!ok) begin nFail++; $display("FAIL t3_timeout: got no oDone required oDone"); end
        nTests++;
        if (resCnt != 3 || intCnt != 0 || validIdx.size() != 0 || doneCnt != 1) begin
            nFail++; $display("FAIL t3_counts: got res=%0d int=%0d val=%0d done=%0d required 3 0 0 1",
                              resCnt, intCnt, validIdx.size(), doneCnt);
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit found;
        clearMon(); respEn = 1; dly = 2; found = 0;
        startSeq(16'd5, 16'd0);
        for (int i = 0; i < 100 && !found; i++) begin
            if (oIntStart === 1'b1 && oStepIdx === 16'd2) found = 1;
            else @(negedge iClk);
        end
        nTests++;
        if (!found) begin nFail++; $display("FAIL t4_reach_step2: got timeout required oIntStart@2"); end
        // Abort lands on the same edge as the interpreter done
        @(negedge iClk); iAbort = 1;
        @(negedge iClk); iAbort = 0;
        nTests++;
        if ({oBusy, oIntStart, oOutValid, oDone, oResStart} !== 5'b0) begin
            nFail++; $display("FAIL t4_abort_clear: got %b required 00000",
                              {oBusy, oIntStart, oOutValid, oDone, oResStart});
        end
        repeat (5) @(negedge iClk);
        nTests++;
        if (doneCnt != 0 || validIdx.size() != 2 || resCnt != 3) begin
            nFail++; $display("FAIL t4_after_abort: got done=%0d val=%0d res=%0d required 0 2 3",
                              doneCnt, validIdx.size(), resCnt);
        end
        clearMon();
        startSeq(16'd2, 16'd0);
        nTests++;
        if (oStepIdx !== 16'd0 || oResStart !== 1'b1 || oBusy !== 1'b1) begin
            nFail++; $display("FAIL t4_restart: got idx=%0d res=%b busy=%b required 0 1 1",
                              oStepIdx, oResStart, oBusy);
        end
        waitDone(200, ok);
        nTests++;
        if (!ok || doneCnt != 1 || validIdx.size() != 2) begin
            nFail++; $display("FAIL t4_restart_done: got ok=%0d done=%0d val=%0d required 1 1 2",
                              ok, doneCnt, validIdx.size());
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        bit found;
        clearMon(); respEn = 1; dly = 3; found = 0;
        startSeq(16'd3, 16'd3);
        for (int i = 0; i < 100 && !found; i++) begin
            if (oResStart === 1'b1 && oStepIdx === 16'd1) found = 1;
            else @(negedge iClk);
        end
        iStart = 1; iNumSteps = 16'd7; iWashout = 16'd0;
        @(negedge iClk); iStart = 0;
        waitDone(200, ok);
        nTests++;
        if (!found || !ok) begin
            nFail++; $display("FAIL t5_flow: got found=%0d ok=%0d required 1 1", found, ok);
        end
        nTests++;
        if (resCnt != 3 || intCnt != 0 || doneCnt != 1 || oStepIdx !== 16'd2) begin
            nFail++; $display("FAIL t5_counts: got res=%0d int=%0d done=%0d idx=%0d required 3 0 1 2",
                              resCnt, intCnt, doneCnt, oStepIdx);
        end
        nTests++;
        if (wideCnt != 0 || monoErr != 0) begin
            nFail++; $display("FAIL t5_pulse_rules: got wide=%0d mono=%0d required 0 0", wideCnt, monoErr);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clearMon(); respEn = 1; dly = 2;
        startSeq(16'd3, 16'd1);
        waitDone(200, ok);
        nTests++;
        if (!ok || resCyc.size() != 3) begin
            nFail++; $display("FAIL t7_flow: got ok=%0d res=%0d required 1 3", ok, resCyc.size());
        end else begin
            nTests++;
            if (resCyc[1] - resCyc[0] != 3 || resCyc[2] - resCyc[1] != 5) begin
                nFail++; $display("FAIL t7_period: got %0d,%0d required 3,5",
                                  resCyc[1] - resCyc[0], resCyc[2] - resCyc[1]);
            end
        end
        nTests++;
        if (validIdx.size() != 2 || validIdx[0] != 16'd1 || validIdx[1] != 16'd2) begin
            nFail++; $display("FAIL t7_valid_idx: got %0d valids required idx 1,2", validIdx.size());
        end
    endtask

    task automatic test_async_reset();
        respEn = 0; clearMon();
        startSeq(16'd4, 16'd1);
        @(negedge iClk); iResDone = 1;
        @(negedge iClk); iResDone = 0;
        @(negedge iClk);
        nTests++;
        if (oResStart !== 1'b1 || oStepIdx !== 16'd1) begin
            nFail++; $display("FAIL t6_setup: got res=%b idx=%0d required 1 1", oResStart, oStepIdx);
        end
        #2 iRst_n = 0;
        #1;
        nTests++;
        if ({oResStart, oIntStart, oOutValid, oBusy, oDone, oStepIdx} !== 21'd0) begin
            nFail++; $display("FAIL t6_async_clear: got %h required 0",
                              {oResStart, oIntStart, oOutValid, oBusy, oDone, oStepIdx});
        end
        clearMon();
        @(negedge iClk); iRst_n = 1;
        @(negedge iClk); iResDone = 1;
        @(negedge iClk); iResDone = 0;
        repeat (4) @(negedge iClk);
        nTests++;
        if (resCnt != 0 || intCnt != 0 || doneCnt != 0 || oBusy !== 1'b0) begin
            nFail++; $display("FAIL t6_stray_done: got res=%0d int=%0d done=%0d busy=%b required 0 0 0 0",
                              resCnt, intCnt, doneCnt, oBusy);
        end
    endtask

    initial begin
        iRst_n = 0; iStart = 0; iAbort = 0; iNumSteps = '0; iWashout = '0;
        clearMon();
        test_reset();
        test_readout();
        test_zero_steps();
        test_washout_covers_all();
        test_abort();
        test_start_while_busy();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
